imem_load_ctrl: RTL and testbench

Sequencer that loads a program into the instruction memory through its debug write port, and owns the core-hold/PC-restart handshake around the load. It sits between the debug byte-stream receiver and the frontend stage. It freezes fetch, drains the pipe, and assembles little-endian bytes into 32-bit instruction words. It writes those words at consecutive word addresses, then restarts fetch at address 0 by forcing the PC-select code for "reset to zero".

---
 rtl/core_pkg.sv | 19 +
 rtl/imem_load_ctrl_byte_packer.sv | 38 +++
 rtl/imem_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the frontend/debug-load logic: PC-select codes and
// the load sequencer state encoding.
package core_pkg;

   localparam logic [1:0] PCSEL_NEXT   = 2'd0;
   localparam logic [1:0] PCSEL_ZERO   = 2'd1;
   localparam logic [1:0] PCSEL_TARGET = 2'd2;
   localparam logic [1:0] PCSEL_HOLD   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_RECV,
      S_WRITE,
      S_RELEASE,
      S_ABORT
   } load_state_t;

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Four-lane little-endian byte assembler. Byte 0 of each word lands in
// bits 7:0. The word output already includes the byte being pushed, so the
// full word is available in the same cycle as word_complete.
module byte_packer (
   input  logic        clk,
   input  logic        nrst,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_complete
);

   logic [31:0] asm_q;
   logic [1:0]  byte_idx;

   // Lane register and lane pointer; the pointer wraps every four bytes.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         asm_q    <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         asm_q    <= '0;
         byte_idx <= '0;
      end else if (push) begin
         asm_q[{byte_idx, 3'b000} +: 8] <= data;
         byte_idx                       <= byte_idx + 2'd1;
      end
   end

   // Merge the incoming byte into its lane for a same-cycle full word.
   always_comb begin
      word                          = asm_q;
      word[{byte_idx, 3'b000} +: 8] = data;
      word_complete                 = push && (byte_idx == 2'd3);
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer: freezes fetch, drains the pipe, packs
// the debug byte stream into words, writes them from address 0 upward and
// finally restarts fetch at PC 0.
module imem_load_ctrl #(
   parameter int MAX_WORDS    = 1024,
   parameter int DRAIN_CYCLES = 2,
   parameter int TIMEOUT      = 65535,
   parameter int LEN_W        = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             imem_wr_en,
   output logic [31:0]      imem_wr_addr,
   output logic [31:0]      imem_wr_data,
   output logic             core_hold,
   output logic [1:0]       pcsel,
   output logic             busy,
   output logic             load_done,
   output logic             load_err
);
   import core_pkg::*;

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int GAP_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   load_state_t        state, next_state;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   word_idx;
   logic [DRAIN_W-1:0] drain_q;
   logic [GAP_W-1:0]   gap_q;

   logic        transfer;
   logic        accept;
   logic        reject;
   logic        len_too_big;
   logic        word_complete;
   logic [31:0] packed_word;

   logic        wr_en_d, hold_d, busy_d, done_d, err_d;
   logic [1:0]  pcsel_d;

   assign byte_ready  = (state == S_RECV);
   assign transfer    = byte_valid && byte_ready;
   assign len_too_big = 32'(load_len) > 32'(MAX_WORDS);

   byte_packer u_packer (
      .clk           (clk),
      .nrst          (nrst),
      .clear         (accept),
      .push          (transfer),
      .data          (byte_data),
      .word          (packed_word),
      .word_complete (word_complete)
   );

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and next values of the registered outputs.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_start) begin
               if (len_too_big) begin
                  reject = 1'b1;
               end else begin
                  accept     = 1'b1;
                  next_state = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               next_state = (len_q == '0) ? S_RELEASE : S_RECV;
            end
         end
         S_RECV: begin
            if (word_complete) begin
               next_state = S_WRITE;
            end else if (!transfer && (gap_q == GAP_W'(TIMEOUT - 1))) begin
               next_state = S_ABORT;
            end
         end
         S_WRITE: begin
            next_state = ((word_idx + LEN_W'(1)) == len_q) ? S_RELEASE : S_RECV;
         end
         S_RELEASE: next_state = S_IDLE;
         S_ABORT:   next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase

      // Outputs are registered from the upcoming state so that each one is
      // aligned with the cycle its state is actually occupied.
      wr_en_d = (next_state == S_WRITE);
      hold_d  = (next_state == S_HOLD) || (next_state == S_RECV) ||
                (next_state == S_WRITE) || (next_state == S_RELEASE);
      pcsel_d = (next_state == S_RELEASE) ? PCSEL_ZERO : PCSEL_NEXT;
      busy_d  = (next_state != S_IDLE);
      done_d  = (state == S_RELEASE);
      err_d   = reject || (next_state == S_ABORT);
   end

   // Length latch, word index, drain counter and inter-byte gap counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         len_q    <= '0;
         word_idx <= '0;
         drain_q  <= '0;
         gap_q    <= '0;
      end else begin
         if (accept) begin
            len_q    <= load_len;
            word_idx <= '0;
            drain_q  <= '0;
         end else if (state == S_HOLD) begin
            drain_q <= drain_q + DRAIN_W'(1);
         end
         if (state == S_WRITE) begin
            word_idx <= word_idx + LEN_W'(1);
         end
         if ((state != S_RECV) || transfer) begin
            gap_q <= '0;
         end else begin
            gap_q <= gap_q + GAP_W'(1);
         end
      end
   end

   // Registered outputs, including the write address/data captured on the
   // fourth byte of each word.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         imem_wr_en   <= 1'b0;
         imem_wr_addr <= '0;
         imem_wr_data <= '0;
         core_hold    <= 1'b0;
         pcsel        <= PCSEL_NEXT;
         busy         <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         imem_wr_en <= wr_en_d;
         core_hold  <= hold_d;
         pcsel      <= pcsel_d;
         busy       <= busy_d;
         load_done  <= done_d;
         load_err   <= err_d;
         if (word_complete) begin
            imem_wr_data <= packed_word;
            imem_wr_addr <= 32'(word_idx);
         end
      end
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl. Expected writes and
// cycle counts come from byte lists and the throughput/latency arithmetic.
module tb_imem_load_ctrl;

   localparam int MAXW  = 1024;
   localparam int DRAIN = 2;
   localparam int TO    = 40;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        load_start = 1'b0;
   logic [15:0] load_len = '0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, imem_wr_en, core_hold, busy, load_done, load_err;
   logic [31:0] imem_wr_addr, imem_wr_data;
   logic [1:0]  pcsel;

   imem_load_ctrl #(
      .MAX_WORDS    (MAXW),
      .DRAIN_CYCLES (DRAIN),
      .TIMEOUT      (TO),
      .LEN_W        (16)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .load_start   (load_start),
      .load_len     (load_len),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .imem_wr_en   (imem_wr_en),
      .imem_wr_addr (imem_wr_addr),
      .imem_wr_data (imem_wr_data),
      .core_hold    (core_hold),
      .pcsel        (pcsel),
      .busy         (busy),
      .load_done    (load_done),
      .load_err     (load_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Observation log, sampled on the falling edge.
   logic [31:0] wr_addr_a [0:4095];
   logic [31:0] wr_data_a [0:4095];
   int n_wr = 0, n_pcsel = 0, n_done = 0, n_err = 0, n_hold = 0, n_ready = 0;
   int n_bad = 0;
   logic prev_wr = 1'b0;
   logic [1:0] prev_pcsel = 2'd0;

   always @(negedge clk) begin
      if (imem_wr_en) begin
         if (n_wr < 4096) begin
            wr_addr_a[n_wr] <= imem_wr_addr;
            wr_data_a[n_wr] <= imem_wr_data;
         end
         n_wr <= n_wr + 1;
      end
      if (pcsel != 2'd0) n_pcsel <= n_pcsel + 1;
      if (load_done) n_done <= n_done + 1;
      if (load_err) n_err <= n_err + 1;
      if (core_hold) n_hold <= n_hold + 1;
      if (byte_ready) n_ready <= n_ready + 1;
      // protocol violations: back-to-back write strobes, pcsel without hold,
      // done not immediately after the single pcsel=1 cycle or with hold still up
      if ((imem_wr_en && prev_wr) || ((pcsel != 2'd0) && !core_hold) ||
          (load_done && ((prev_pcsel != 2'd1) || core_hold)) ||
          ((pcsel != 2'd0) && (pcsel != 2'd1)))
         n_bad <= n_bad + 1;
      prev_wr    <= imem_wr_en;
      prev_pcsel <= pcsel;
   end

   logic [7:0] bytes_a [0:4095];
   int b_wr, b_pcsel, b_done, b_err, b_hold, b_ready, b_bad;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_wr = n_wr; b_pcsel = n_pcsel; b_done = n_done; b_err = n_err;
      b_hold = n_hold; b_ready = n_ready; b_bad = n_bad;
   endtask

   task automatic fill_random(input int nbytes);
      for (int i = 0; i < nbytes; i++) bytes_a[i] = 8'($urandom);
   endtask

   // Offer bytes_a[0..nbytes-1]; mode 0 = always valid, 1 = every other
   // cycle, 2 = random. Optionally fires a stray load_start mid-stream.
   task automatic feed(input int nbytes, input int mode, input bit restart);
      int sent = 0;
      int cyc = 0;
      bit tog = 1'b1;
      while (sent < nbytes && cyc < nbytes * 8 + 20) begin
         case (mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = tog;
            default: byte_valid = 1'($urandom_range(0, 1));
         endcase
         tog = ~tog;
         byte_data  = bytes_a[sent];
         load_start = restart && (cyc == 3);
         if (restart) load_len = 16'd7;
         @(negedge clk);
         if (byte_valid && byte_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      byte_valid = 1'b0;
      load_start = 1'b0;
      chk("feed_sent", 64'(sent), 64'(nbytes));
   endtask

   // Start a load and wait for first byte_ready; checks hold and latency.
   task automatic start_load(input string tag, input int len);
      int n;
      @(posedge clk); #1;
      load_start = 1'b1;
      load_len   = 16'(len);
      @(posedge clk); #1;
      load_start = 1'b0;
      load_len   = 16'($urandom);
      chk({tag, "_hold_on"}, 64'(core_hold), 64'd1);
      if (len > 0) begin
         n = 1;
         while (!byte_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk({tag, "_latency"}, 64'(n), 64'(DRAIN + 1));
      end
   endtask

   task automatic do_load(input string tag, input int len, input int mode,
                          input bit restart, input int nbytes, input bit expect_done);
      int n;
      logic [31:0] w;
      snap();
      start_load(tag, len);
      if (nbytes > 0) feed(nbytes, mode, restart);
      n = 0;
      while (!(load_done || load_err) && n < TO + 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_end_pulse"}, 64'(expect_done ? load_done : load_err), 64'd1);
      chk({tag, "_hold_end"}, 64'(core_hold), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
      chk({tag, "_nwrites"}, 64'(n_wr - b_wr), 64'(expect_done ? len : 0));
      if (expect_done && (n_wr - b_wr) == len) begin
         for (int i = 0; i < len; i++) begin
            w = {bytes_a[4*i+3], bytes_a[4*i+2], bytes_a[4*i+1], bytes_a[4*i]};
            chk({tag, "_addr"}, 64'(wr_addr_a[b_wr+i]), 64'(i));
            chk({tag, "_data"}, 64'(wr_data_a[b_wr+i]), 64'(w));
         end
      end
      chk({tag, "_pcsel_cycles"}, 64'(n_pcsel - b_pcsel), 64'(expect_done ? 1 : 0));
      chk({tag, "_done_cnt"}, 64'(n_done - b_done), 64'(expect_done ? 1 : 0));
      chk({tag, "_err_cnt"}, 64'(n_err - b_err), 64'(expect_done ? 0 : 1));
      chk({tag, "_protocol"}, 64'(n_bad - b_bad), 64'd0);
      if (expect_done && mode == 0)
         chk({tag, "_hold_cycles"}, 64'(n_hold - b_hold), 64'(DRAIN + 5 * len + 1));
      if (!expect_done)
         chk({tag, "_silent_ready"}, 64'(n_ready - b_ready), 64'(nbytes + TO));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int len;
      int mode;

      // reset state
      #3;
      chk("reset_ctrl", 64'({byte_ready, imem_wr_en, core_hold, pcsel, busy, load_done, load_err}), 64'd0);
      chk("reset_addr", 64'(imem_wr_addr), 64'd0);
      chk("reset_data", 64'(imem_wr_data), 64'd0);
      @(posedge clk); #2;
      nrst = 1'b1;

      // two-word program, fixed bytes, back-to-back stream
      bytes_a[0] = 8'h13; bytes_a[1] = 8'h00; bytes_a[2] = 8'h00; bytes_a[3] = 8'h00;
      bytes_a[4] = 8'h93; bytes_a[5] = 8'h00; bytes_a[6] = 8'h10; bytes_a[7] = 8'h00;
      do_load("prog2", 2, 0, 1'b0, 8, 1'b1);
      chk("prog2_word0", 64'(wr_data_a[b_wr]), 64'h0000_0013);
      chk("prog2_word1", 64'(wr_data_a[b_wr+1]), 64'h0010_0093);

      // asynchronous reset in the middle of RECV after two bytes
      fill_random(12);
      snap();
      start_load("rstmid", 3);
      feed(2, 0, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      chk("rstmid_ctrl", 64'({byte_ready, imem_wr_en, core_hold, pcsel, busy, load_done, load_err}), 64'd0);
      chk("rstmid_addr", 64'(imem_wr_addr), 64'd0);
      chk("rstmid_data", 64'(imem_wr_data), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      nrst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rstmid_no_pulse", 64'((n_done - b_done) + (n_err - b_err)), 64'd0);
      chk("rstmid_idle", 64'(busy), 64'd0);

      // zero-length load
      do_load("len0", 0, 0, 1'b0, 0, 1'b1);

      // oversize length is rejected without touching the core
      snap();
      @(posedge clk); #1;
      load_start = 1'b1;
      load_len   = 16'(MAXW + 1);
      @(posedge clk); #1;
      load_start = 1'b0;
      chk("reject_err", 64'(load_err), 64'd1);
      chk("reject_busy", 64'({busy, core_hold}), 64'd0);
      @(posedge clk); #1;
      chk("reject_err_1cyc", 64'(load_err), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("reject_quiet", 64'((n_wr - b_wr) + (n_hold - b_hold) + (n_pcsel - b_pcsel)), 64'd0);
      chk("reject_err_cnt", 64'(n_err - b_err), 64'd1);

      // inter-byte timeout after three bytes of a one-word load
      fill_random(4);
      do_load("timeout", 1, 0, 1'b0, 3, 1'b0);

      // byte_valid every other cycle with a stray load_start mid-stream
      fill_random(12);
      do_load("toggle", 3, 1, 1'b1, 12, 1'b1);

      // randomized loads
      for (int k = 0; k < 5; k++) begin
         len  = $urandom_range(1, 6);
         mode = $urandom_range(0, 2);
         fill_random(4 * len);
         do_load("rand", len, mode, 1'b0, 4 * len, 1'b1);
      end

      // full-capacity load reaches the last word address
      fill_random(4 * MAXW);
      do_load("full", MAXW, 0, 1'b0, 4 * MAXW, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
